npc_mem_responder: RTL and testbench
====================================

Name: npc_mem_responder

Overview:
Memory-side responder for the NPC core's data-memory port. It replaces the DPI npcmem_read/npcmem_write calls with a synthesizable word-addressed SRAM model. The block accepts one load/store request at a time over a valid/ready handshake and returns the response after a fixed, configurable latency over a second valid/ready handshake. It sits between the core's memory-access stage and on-chip storage.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width (fixed at 32; byte lanes = 4)
DEPTH_LOG2, 10, log2 of word count (default 1024 words = 4 KiB)
LATENCY, 2, cycles from the accept edge to rsp_valid high; legal range 1..15
BASE, 32'h8000_0000, byte address of word 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address; bits [1:0] ignored (word aligned)
req_wdata  in  DATA_W  store data
req_wmask  in  8  byte enables; bits [3:0] map to byte lanes 0..3; bits [7:4] are ignored
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts the response
rsp_rdata  out  DATA_W  load data; 0 for stores and for errors
rsp_err  out  1  address outside [BASE, BASE + 4*2^DEPTH_LOG2)

Behaviour:
- Reset, sampled on a clk rising edge with rst = 1:
  - State goes to IDLE.
  - req_ready is 1 from the first cycle after reset.
  - rsp_valid, rsp_err and rsp_rdata are 0.
  - Latency counter is 0. Request capture registers are 0.
  - SRAM contents are not cleared.
- Single outstanding request. req_ready = (state == IDLE), a registered state decode with no combinational path from req_valid.
- Accept:
  - A request is accepted on an edge where req_valid && req_ready.
  - On that edge the block captures we, the word index (addr − BASE) >> 2, wdata, wmask[3:0] and the range-check result.
- States:
  - IDLE: on accept, go to WAIT with counter = LATENCY−1 if LATENCY > 1; otherwise go directly to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, the next edge moves to RESP.
  - RESP: rsp_valid = 1. Hold rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready stays 0 in WAIT and RESP, so there is no overlap. Throughput is one transaction per LATENCY+1 cycles minimum.
- Timing: with the accept at edge T, rsp_valid is high in the cycle after edge T+LATENCY−1. For LATENCY = 1, rsp_valid rises in the cycle after accept.
- Commit point: the store write and the load read both happen on the edge entering RESP.
  - Store: write each byte lane whose mask bit is 1; keep the other lanes.
  - Load: register the full word into rsp_rdata.
  - Stores return rsp_rdata = 0.
- Out of range (rsp_err = 1): the SRAM is not written and rsp_rdata = 0. The response still takes the full LATENCY.
- Load after store to the same address (sequential transactions) returns the new data.
- wmask[3:0] = 0 on a store is a legal no-op write, rsp_err = 0.
- Reset mid-operation (WAIT or RESP):
  - Abort the transaction and return to IDLE.
  - A store not yet committed is dropped.
  - A response held in RESP is discarded and rsp_valid is 0 next cycle.
- rsp_ready high while not in RESP has no effect. req_valid while req_ready = 0 is ignored; the core must hold its request.
- Width rules:
  - Range check uses a full ADDR_W-bit unsigned compare: addr >= BASE and addr − BASE < 4*2^DEPTH_LOG2.
  - No wrap-around; addresses below BASE are errors.
  - LATENCY counter is 4 bits.

Decomposition:
- Shared package npc_mem_pkg:
  - state encoding IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2
  - DATA_W
  - the lane count constant NLANES = 4
  - the mask-to-bit-enable expansion function
- One sub-module, npc_mem_array:
  - single-port synchronous SRAM, 2^DEPTH_LOG2 x 32
  - per-byte write enable
  - registered read
- The FSM, counter and range check live in npc_mem_responder.

Test Plan:
1. Reset for 2 cycles then release. Required: req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
2. LATENCY = 2: store 0xDEADBEEF, mask 8'h0F, at 0x8000_0010 accepted at edge T. Required: rsp_valid in the cycle after edge T+1, rsp_err = 0, rsp_rdata = 0. A following load of 0x8000_0013 returns 0xDEADBEEF.
3. Store 0x1234_5678, mask 8'h03, over step 2's word. Required: a load returns 0xDEAD5678. Mask 8'hF0 then leaves the word unchanged.
4. Load or store at 0x7FFF_FFFC and at 0x8000_1000. Required: rsp_err = 1, rsp_rdata = 0, and the store does not modify the word at 0x8000_0000.
5. Hold rsp_ready = 0 for 5 cycles in RESP while req_valid = 1. Required: rsp_valid, rsp_rdata and rsp_err stay stable, req_ready = 0. On the rsp_ready edge, next cycle rsp_valid = 0 and req_ready = 1.
6. Assert rst in WAIT during a store of 0xCAFEF00D to 0x8000_0010. Required: IDLE next cycle and rsp_valid = 0. A subsequent load returns 0xDEAD5678 (store dropped).

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared definitions for the NPC data-memory responder.
//   - state_t      : responder FSM encoding (IDLE / WAIT / RESP)
//   - DATA_W       : memory word width (fixed at 32)
//   - NLANES       : byte lanes per word
//   - mask_to_bits : expands a per-lane byte mask into a per-bit enable
package npc_mem_pkg;

  localparam int DATA_W = 32;
  localparam int NLANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] mask_to_bits(input logic [NLANES-1:0] m);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int l = 0; l < NLANES; l++) begin
      b[8*l +: 8] = {8{m[l]}};
    end
    return b;
  endfunction

endpackage

// File: rtl/npc_mem_array.sv
// Single-port synchronous word SRAM with per-byte write enables.
// Ports:
//   clk   : clock, rising edge
//   en    : access enable; a read (and optional write) happens on this edge
//   wmask : byte-lane write enables, lane 0 = bits [7:0]
//   addr  : word index
//   wdata : store data
//   rdata : registered read data (old contents on a simultaneous write)
// Contents are never reset.
module npc_mem_array
  import npc_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [NLANES-1:0]     wmask,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] bit_en;

  assign bit_en = mask_to_bits(wmask);

  always_ff @(posedge clk) begin
    if (en) begin
      if (|wmask) begin
        mem[addr] <= (mem[addr] & ~bit_en) | (wdata & bit_en);
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/npc_mem_responder.sv
// Memory-side responder for the NPC core data port: one outstanding
// load/store, accepted over req_valid/req_ready and answered after a fixed
// LATENCY over rsp_valid/rsp_ready.
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only when idle)
//   req_we                    : 1 = store, 0 = load
//   req_addr                  : byte address, low two bits ignored
//   req_wdata, req_wmask[3:0] : store data and byte enables ([7:4] ignored)
//   rsp_valid/rsp_ready       : response handshake
//   rsp_rdata                 : load data, 0 for stores and errors
//   rsp_err                   : address outside [BASE, BASE + 4*2^DEPTH_LOG2)
module npc_mem_responder #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter int                LATENCY    = 2,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  import npc_mem_pkg::*;

  localparam logic [3:0]     LAT_M1 = 4'(LATENCY - 1);
  // Size of the window in bytes, one bit wider than the address so the
  // compare never overflows.
  localparam logic [ADDR_W:0] SPAN  =
    {{(ADDR_W - DEPTH_LOG2 - 2){1'b0}}, 1'b1, {(DEPTH_LOG2 + 2){1'b0}}};

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NLANES-1:0]     wmask_q;
  logic                  err_q;
  logic                  rsp_err_q;
  logic                  rd_sel_q;

  logic [ADDR_W-1:0]     off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  accept;
  logic                  commit;
  logic                  arr_we;
  logic                  arr_err;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [DATA_W-1:0]     arr_wdata;
  logic [NLANES-1:0]     arr_mask;
  logic [DATA_W-1:0]     arr_rdata;
  logic                  unused_mask_hi;

  assign unused_mask_hi = ^req_wmask[7:4];

  assign off      = req_addr - BASE;
  assign in_range = (req_addr >= BASE) && ({1'b0, off} < SPAN);
  assign req_idx  = off[DEPTH_LOG2+1:2];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

  assign accept = req_valid && req_ready;

  // The SRAM is touched only on the edge that enters RESP. With LATENCY = 1
  // that edge is the accept edge itself, so the live request is used
  // instead of the not-yet-loaded capture registers. Reset suppresses the
  // commit so an in-flight store is dropped.
  assign commit = !rst && ((accept && (LATENCY == 1)) ||
                           ((state == WAIT) && (cnt == 4'd1)));

  always_comb begin
    arr_we    = we_q;
    arr_err   = err_q;
    arr_idx   = idx_q;
    arr_wdata = wdata_q;
    arr_mask  = wmask_q;
    if (state == IDLE) begin
      arr_we    = req_we;
      arr_err   = !in_range;
      arr_idx   = req_idx;
      arr_wdata = req_wdata;
      arr_mask  = req_wmask[NLANES-1:0];
    end
  end

  npc_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (commit && !arr_err),
    .wmask(arr_we ? arr_mask : '0),
    .addr (arr_idx),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask[NLANES-1:0];
            err_q   <= !in_range;
            if (LATENCY > 1) begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end else begin
              state     <= RESP;
              rsp_err_q <= !in_range;
              rd_sel_q  <= !req_we && in_range;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            cnt       <= '0;
            rsp_err_q <= err_q;
            rd_sel_q  <= !we_q && !err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_err_q <= 1'b0;
            rd_sel_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_responder.sv
module tb_npc_mem_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int unsigned];

  npc_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(LAT), .BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: range check, masked store, load lookup.
  task automatic push_expect(input txn_t t);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] w;
    int unsigned idx;
    off     = t.addr - BASE;
    e.err   = !((t.addr >= BASE) && (off < 32'h0000_1000));
    e.rdata = 32'h0;
    idx     = int'(off >> 2);
    if (!e.err) begin
      if (t.we) begin
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int l = 0; l < 4; l++) begin
          if (t.wmask[l]) w[8*l +: 8] = t.wdata[8*l +: 8];
        end
        model[idx] = w;
      end else begin
        e.rdata = model.exists(idx) ? model[idx] : 32'h0;
      end
    end
    sb.push_back(e);
  endtask

  // Presents a request and returns once it has been accepted (#1 after the edge).
  task automatic issue(input txn_t t, input bit keep, output bit ok);
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = t.we;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_wmask = t.wmask;
    for (int n = 0; n < 20 && !req_ready; n++) begin
      @(posedge clk); #1;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", t.addr, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    push_expect(t);
    if (!keep) req_valid = 1'b0;
    ok = 1'b1;
  endtask

  // Counts edges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = (rsp_valid === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl ready/valid/err=%b required 100", {req_ready, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h required 0", rsp_rdata);
    end
  endtask

  task automatic test_store_load;
    txn_t tbl[$];
    exp_t e;
    int   lat;
    bit   ok;
    tbl = '{'{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F},
            '{1'b0, 32'h8000_0013, 32'h0,         8'h00},
            '{1'b1, 32'h8000_0FFC, 32'hA5A5_0F0F, 8'h0F},
            '{1'b0, 32'h8000_0FFC, 32'h0,         8'h00}};
    foreach (tbl[i]) begin
      issue(tbl[i], 1'b0, ok);
      if (!ok) continue;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL sl_busy[%0d] req_ready=%b required 0", i, req_ready);
      end
      wait_rsp(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != LAT - 1) begin
        errors++;
        $display("FAIL sl_latency[%0d] got %0d edges required %0d", i, lat, LAT - 1);
      end
      checks++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL sl_rsp[%0d] got %h/%b required %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL sl_release[%0d] valid/ready=%b%b required 01", i, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_mask;
    txn_t tbl[$];
    exp_t e;
    int   lat;
    bit   ok;
    tbl = '{'{1'b1, 32'h8000_0010, 32'h1234_5678, 8'h03},
            '{1'b0, 32'h8000_0010, 32'h0,         8'h00},
            '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0},
            '{1'b1, 32'h8000_0011, 32'h0BAD_0BAD, 8'h00},
            '{1'b0, 32'h8000_0012, 32'h0,         8'h00}};
    foreach (tbl[i]) begin
      issue(tbl[i], 1'b0, ok);
      if (!ok) continue;
      wait_rsp(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL mask_rsp[%0d] got %h/%b required %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_range;
    txn_t tbl[$];
    exp_t e;
    int   lat;
    bit   ok;
    tbl = '{'{1'b1, 32'h8000_0000, 32'h1122_3344, 8'h0F},
            '{1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00},
            '{1'b1, 32'h7FFF_FFFC, 32'hEEEE_EEEE, 8'h0F},
            '{1'b1, 32'h8000_1000, 32'hDDDD_DDDD, 8'h0F},
            '{1'b0, 32'h8000_1000, 32'h0,         8'h00},
            '{1'b1, 32'h0000_0000, 32'hCCCC_CCCC, 8'h0F},
            '{1'b0, 32'h8000_0000, 32'h0,         8'h00}};
    foreach (tbl[i]) begin
      issue(tbl[i], 1'b0, ok);
      if (!ok) continue;
      wait_rsp(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != LAT - 1) begin
        errors++;
        $display("FAIL range_latency[%0d] got %0d edges required %0d", i, lat, LAT - 1);
      end
      checks++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL range_rsp[%0d] got %h/%b required %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    txn_t t;
    exp_t e;
    int   lat;
    bit   ok;
    t = '{1'b0, 32'h8000_0010, 32'h0, 8'h00};
    issue(t, 1'b1, ok);
    if (!ok) return;
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL bp_rsp got %h/%b required %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid/ready=%b%b data=%h err=%b required 10 %h %b",
                 c, rsp_valid, req_ready, rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid/ready=%b%b required 01", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    txn_t t;
    exp_t e;
    int   lat;
    bit   ok;
    // Dropped store: driven by hand so the model never sees it.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0010;
    req_wdata = 32'hCAFE_F00D; req_wmask = 8'h0F;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_wait ready/valid=%b%b required 00", req_ready, rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_idle ready/valid=%b%b required 10", req_ready, rsp_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_rsp rsp_valid=%b required 0", rsp_valid);
    end
    t = '{1'b0, 32'h8000_0010, 32'h0, 8'h00};
    issue(t, 1'b0, ok);
    if (!ok) return;
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL rm_load got %h/%b required %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_mask();
    test_range();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
